// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port memory responder with fixed latency
// One request in flight; byte-enable stores, sign/zero-extended loads.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_error
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_commit;
  logic            w_err;
  logic [IDXW-1:0] w_idx;
  logic [31:0]     w_word;
  logic [31:0]     w_lane;
  logic [31:0]     w_load;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;

  assign w_accept    = (r_state == S_IDLE) && i_req_valid;
  assign w_commit    = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_idx       = r_addr[IDXW+1:2];
  assign w_word      = r_mem[w_idx];
  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_error = r_rsp_error;

  always_comb begin
    w_err = 1'b0;
    if (r_size == 2'b11) w_err = 1'b1;
    if (r_size == 2'b01 && r_addr[0]) w_err = 1'b1;
    if (r_size == 2'b10 && r_addr[1:0] != 2'b00) w_err = 1'b1;
    if ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS)) w_err = 1'b1;
  end

  // Aligned accesses only reach here without error, so a plain lane shift suffices.
  always_comb begin
    w_lane = w_word >> {r_addr[1:0], 3'b000};
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'h0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load = r_unsigned ? {16'h0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req_valid) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= 32'h0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_wdata     <= 32'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write    <= i_req_write;
        r_addr     <= i_req_addr;
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_wdata    <= i_req_wdata;
        r_cnt      <= 4'(LATENCY - 1);
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rsp_error <= w_err;
        r_rsp_rdata <= (w_err || r_write) ? 32'h0 : w_load;
      end
    end
  end

  // Storage has no reset; a reset in the commit cycle suppresses the write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_commit && r_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
// Three builds (LATENCY 2, 1, 15) checked against a byte-array memory model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst          [3];
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_write    [3];
  logic [31:0] req_addr     [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_wdata    [3];
  logic        rsp_valid    [3];
  logic        rsp_ready    [3];
  logic [31:0] rsp_rdata    [3];
  logic        rsp_error    [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem_b [logic [33:0]];
  logic [31:0] exp_rdata [3];
  logic        exp_err   [3];
  int          push_cnt  [3];
  int          pop_cnt   [3];

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 15))
    ) u_dut (
      .i_clk(clk), .i_rst(rst[g]),
      .i_req_valid(req_valid[g]), .o_req_ready(req_ready[g]),
      .i_req_write(req_write[g]), .i_req_addr(req_addr[g]),
      .i_req_size(req_size[g]), .i_req_unsigned(req_unsigned[g]),
      .i_req_wdata(req_wdata[g]),
      .o_rsp_valid(rsp_valid[g]), .i_rsp_ready(rsp_ready[g]),
      .o_rsp_rdata(rsp_rdata[g]), .o_rsp_error(rsp_error[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: a byte-addressed map, keyed by unit so each build has its own storage.
  task automatic model(input int u, input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd,
                       output logic e, output logic [31:0] d);
    int nb;
    logic [31:0] v;
    logic [31:0] hi_mask;
    e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
        || ((a >> 2) >= DEPTH);
    d = 32'h0;
    nb = 1 << sz;
    if (!e && !w) begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_b[{u[1:0], a + 32'(i)}]) << (8 * i));
      if (!uns && nb < 4 && v[8*nb-1]) begin
        hi_mask = 32'hFFFF_FFFF << (8 * nb);
        v = v | hi_mask;
      end
      d = v;
    end
    if (!e && w) begin
      for (int i = 0; i < nb; i++) mem_b[{u[1:0], a + 32'(i)}] = 8'(wd >> (8 * i));
    end
  endtask

  // Response checker: every cycle a response is presented it must match the model.
  initial begin
    for (int u = 0; u < 3; u++) pop_cnt[u] = 0;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        if (rsp_valid[u] === 1'b1) begin
          if (push_cnt[u] == pop_cnt[u]) begin
            chk("unexpected_rsp_valid", 32'(rsp_valid[u]), 32'h0);
          end else begin
            chk("rsp_rdata", rsp_rdata[u], exp_rdata[u]);
            chk("rsp_error", 32'(rsp_error[u]), 32'(exp_err[u]));
            if (rsp_ready[u]) pop_cnt[u]++;
          end
        end
      end
    end
  end

  task automatic req(input int u, input logic w, input logic [31:0] a, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd, input int hold,
                     input logic lit_en, input logic [31:0] lit_d, input logic lit_e);
    int lat;
    int waited;
    logic e;
    logic [31:0] d;
    lat = (u == 0) ? 2 : ((u == 1) ? 1 : 15);
    waited = 0;
    while (!req_ready[u] && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("req_ready_idle", 32'(req_ready[u]), 32'h1);
    model(u, w, a, sz, uns, wd, e, d);
    req_valid[u] = 1'b1; req_write[u] = w; req_addr[u] = a;
    req_size[u] = sz; req_unsigned[u] = uns; req_wdata[u] = wd;
    rsp_ready[u] = (hold == 0);
    @(posedge clk); #1;
    req_valid[u] = 1'b0; req_write[u] = ~w; req_addr[u] = 32'hFFFF_FFFC;
    req_size[u] = 2'b11; req_unsigned[u] = ~uns; req_wdata[u] = 32'h5A5A_5A5A;
    exp_rdata[u] = d; exp_err[u] = e; push_cnt[u]++;
    for (int n = 0; n <= lat; n++) begin
      chk("rsp_valid_timing", 32'(rsp_valid[u]), (n == lat) ? 32'h1 : 32'h0);
      chk("req_ready_busy", 32'(req_ready[u]), 32'h0);
      if (n < lat) begin
        @(posedge clk); #1;
      end
    end
    if (lit_en) begin
      chk("lit_rdata", rsp_rdata[u], lit_d);
      chk("lit_error", 32'(rsp_error[u]), 32'(lit_e));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid[u]), 32'h1);
      chk("bp_req_ready", 32'(req_ready[u]), 32'h0);
    end
    rsp_ready[u] = 1'b1;
    @(posedge clk); #1;
    chk("rsp_done_valid", 32'(rsp_valid[u]), 32'h0);
    chk("rsp_done_ready", 32'(req_ready[u]), 32'h1);
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      rst[u] = 1'b1; req_valid[u] = 1'b0; req_write[u] = 1'b0; req_addr[u] = 32'h0;
      req_size[u] = 2'b00; req_unsigned[u] = 1'b0; req_wdata[u] = 32'h0;
      rsp_ready[u] = 1'b1; push_cnt[u] = 0; exp_rdata[u] = 32'h0; exp_err[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      chk("reset_req_ready", 32'(req_ready[u]), 32'h1);
      chk("reset_rsp_valid", 32'(rsp_valid[u]), 32'h0);
      chk("reset_rsp_rdata", rsp_rdata[u], 32'h0);
      chk("reset_rsp_error", 32'(rsp_error[u]), 32'h0);
      rst[u] = 1'b0;
    end

    // word store / load
    req(0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 0, 1, 32'h0, 0);
    req(0, 0, 32'h10, 2'b10, 0, 32'h0, 0, 1, 32'hDEADBEEF, 0);
    // extension cases
    req(0, 1, 32'h20, 2'b10, 0, 32'h000080F0, 0, 0, 32'h0, 0);
    req(0, 0, 32'h20, 2'b00, 0, 32'h0, 0, 1, 32'hFFFFFFF0, 0);
    req(0, 0, 32'h20, 2'b00, 1, 32'h0, 0, 1, 32'h000000F0, 0);
    req(0, 0, 32'h20, 2'b01, 0, 32'h0, 0, 1, 32'hFFFF80F0, 0);
    req(0, 0, 32'h20, 2'b01, 1, 32'h0, 0, 1, 32'h000080F0, 0);
    req(0, 0, 32'h21, 2'b00, 0, 32'h0, 0, 1, 32'hFFFFFF80, 0);
    req(0, 1, 32'h23, 2'b00, 0, 32'hAAAAAA7F, 0, 0, 32'h0, 0);
    req(0, 0, 32'h20, 2'b10, 0, 32'h0, 0, 1, 32'h7F0080F0, 0);
    req(0, 0, 32'h22, 2'b01, 0, 32'h0, 0, 1, 32'h00007F00, 0);
    // half store into upper lanes
    req(0, 1, 32'h40, 2'b10, 0, 32'h11223344, 0, 0, 32'h0, 0);
    req(0, 1, 32'h42, 2'b01, 0, 32'h5555CAFE, 0, 0, 32'h0, 0);
    req(0, 0, 32'h40, 2'b10, 0, 32'h0, 0, 1, 32'hCAFE3344, 0);
    req(0, 0, 32'h42, 2'b01, 0, 32'h0, 0, 1, 32'hFFFFCAFE, 0);
    // errors
    req(0, 0, 32'h22, 2'b10, 0, 32'h0, 0, 1, 32'h0, 1);
    req(0, 0, 32'h21, 2'b01, 0, 32'h0, 0, 1, 32'h0, 1);
    req(0, 0, 32'h20, 2'b11, 0, 32'h0, 0, 1, 32'h0, 1);
    req(0, 0, 32'(4 * DEPTH), 2'b10, 0, 32'h0, 0, 1, 32'h0, 1);
    req(0, 1, 32'h22, 2'b10, 0, 32'h0000FFFF, 0, 1, 32'h0, 1);
    req(0, 0, 32'h20, 2'b10, 0, 32'h0, 0, 1, 32'h7F0080F0, 0);
    // last in-range word
    req(0, 1, 32'(4 * DEPTH - 4), 2'b10, 0, 32'h0BADF00D, 0, 0, 32'h0, 0);
    req(0, 0, 32'(4 * DEPTH - 4), 2'b10, 0, 32'h0, 0, 1, 32'h0BADF00D, 0);
    // back-pressure
    req(0, 0, 32'h10, 2'b10, 0, 32'h0, 5, 1, 32'hDEADBEEF, 0);

    // reset while a store is pending
    req(0, 1, 32'h30, 2'b10, 0, 32'hAAAAAAAA, 0, 0, 32'h0, 0);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30;
    req_size[0] = 2'b10; req_wdata[0] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("rst_pre_busy", 32'(req_ready[0]), 32'h0);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    chk("rst_req_ready", 32'(req_ready[0]), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'h0);
    req(0, 0, 32'h30, 2'b10, 0, 32'h0, 0, 1, 32'hAAAAAAAA, 0);

    // LATENCY=1 and LATENCY=15 builds
    req(1, 1, 32'h100, 2'b10, 0, 32'hCAFEF00D, 0, 0, 32'h0, 0);
    req(1, 0, 32'h102, 2'b01, 1, 32'h0, 0, 1, 32'h0000CAFE, 0);
    req(2, 1, 32'h200, 2'b10, 0, 32'h89ABCDEF, 0, 0, 32'h0, 0);
    req(2, 0, 32'h200, 2'b00, 0, 32'h0, 2, 1, 32'hFFFFFFEF, 0);

    repeat (2) @(posedge clk);
    for (int u = 0; u < 3; u++) chk("all_responses_seen", 32'(pop_cnt[u]), 32'(push_cnt[u]));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
